// File: rtl/bcd_arb_pkg.sv
// Shared widths and controller states for the time-shared BCD converter.
// Pure declarations: no logic, no latency, no flow control.
package bcd_arb_pkg;
   localparam int BIN_W   = 6;
   localparam int DIGIT_W = 4;

   typedef enum logic {IDLE, CONVERT} state_t;
endpackage

// File: rtl/bcd.sv
// Combinational 6-bit binary to tens/ones BCD converter.
// Zero latency, no flow control.
module bcd
   import bcd_arb_pkg::*;
(
   input  logic [BIN_W-1:0]   i_bin,
   output logic [DIGIT_W-1:0] o_ones,
   output logic [DIGIT_W-1:0] o_tens
);

   logic [DIGIT_W-1:0] w_tens;

   // Threshold ladder: the largest multiple of ten not above the input gives the tens digit.
   always_comb begin
      w_tens = '0;
      for (int k = 1; k <= 6; k++) begin
         if (int'(i_bin) >= 10 * k) w_tens = DIGIT_W'(k);
      end
   end

   assign o_tens = w_tens;
   assign o_ones = DIGIT_W'(int'(i_bin) - int'(w_tens) * 10);

endmodule

// File: rtl/bcd_arbiter.sv
// Round-robin sharing of one bcd converter among CH requesters; ack one cycle after sampling, done one cycle later.
// Requests are levels sampled only in IDLE, so a requester simply waits (holds req) until granted; throughput one per 2 cycles.
module bcd_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int CH = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH-1:0]         req,
   input  logic [CH*BIN_W-1:0]   operand,
   output logic [CH-1:0]         ack,
   output logic [CH-1:0]         done,
   output logic [CH*DIGIT_W-1:0] ones,
   output logic [CH*DIGIT_W-1:0] tens,
   output logic [CH-1:0]         valid,
   output logic                  busy
);

   localparam int GW = (CH > 1) ? $clog2(CH) : 1;

   state_t                  r_state;
   logic [BIN_W-1:0]        r_op_q;
   logic [GW-1:0]           r_gnt_q;
   logic [GW-1:0]           r_last;
   logic [CH-1:0]           r_ack;
   logic [CH-1:0]           r_done;
   logic [CH-1:0]           r_valid;
   logic [CH*DIGIT_W-1:0]   r_ones;
   logic [CH*DIGIT_W-1:0]   r_tens;

   logic [GW-1:0]           w_win;
   logic [DIGIT_W-1:0]      w_ones;
   logic [DIGIT_W-1:0]      w_tens;

   // First asserted request strictly after the previous winner, wrapping around.
   function automatic logic [GW-1:0] rr_pick(input logic [CH-1:0] i_req,
                                             input logic [GW-1:0] i_last);
      logic [GW-1:0] w_sel;
      logic          w_found;
      int            idx;
      w_sel   = i_last;
      w_found = 1'b0;
      for (int k = 1; k <= CH; k++) begin
         idx = (int'(i_last) + k) % CH;
         if (!w_found && i_req[idx]) begin
            w_sel   = GW'(idx);
            w_found = 1'b1;
         end
      end
      return w_sel;
   endfunction

   assign w_win = rr_pick(req, r_last);

   bcd u_bcd (
      .i_bin  (r_op_q),
      .o_ones (w_ones),
      .o_tens (w_tens)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op_q  <= '0;
         r_gnt_q <= '0;
         r_last  <= GW'(CH - 1);
         r_ack   <= '0;
         r_done  <= '0;
         r_valid <= '0;
         r_ones  <= '0;
         r_tens  <= '0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_op_q       <= operand[int'(w_win)*BIN_W +: BIN_W];
                  r_gnt_q      <= w_win;
                  r_last       <= w_win;
                  r_ack[w_win] <= 1'b1;
                  r_state      <= CONVERT;
               end
            end
            CONVERT: begin
               r_ones[int'(r_gnt_q)*DIGIT_W +: DIGIT_W] <= w_ones;
               r_tens[int'(r_gnt_q)*DIGIT_W +: DIGIT_W] <= w_tens;
               r_valid[r_gnt_q] <= 1'b1;
               r_done[r_gnt_q]  <= 1'b1;
               r_state          <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack   = r_ack;
   assign done  = r_done;
   assign ones  = r_ones;
   assign tens  = r_tens;
   assign valid = r_valid;
   assign busy  = (r_state == CONVERT);

endmodule

// File: tb/tb_bcd_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the shared converter.
module tb_bcd_arbiter;
   localparam int CH = 4;

   logic            clk;
   logic            rst_n;
   logic [CH-1:0]   req;
   logic [CH*6-1:0] operand;
   logic [CH-1:0]   ack;
   logic [CH-1:0]   done;
   logic [CH*4-1:0] ones;
   logic [CH*4-1:0] tens;
   logic [CH-1:0]   valid;
   logic            busy;

   int total = 0;
   int bad   = 0;

   bcd_arbiter #(.CH(CH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .operand (operand),
      .ack     (ack),
      .done    (done),
      .ones    (ones),
      .tens    (tens),
      .valid   (valid),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a request either is in flight (m_pend) or the arbiter picks a new one.
   bit              m_init = 0;
   int              m_pend;
   int              m_last;
   int              m_op;
   logic [CH-1:0]   m_ack;
   logic [CH-1:0]   m_done;
   logic [CH-1:0]   m_valid;
   logic [CH*4-1:0] m_ones;
   logic [CH*4-1:0] m_tens;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_init  = 1;
         m_pend  = -1;
         m_last  = CH - 1;
         m_op    = 0;
         m_ack   = '0;
         m_done  = '0;
         m_valid = '0;
         m_ones  = '0;
         m_tens  = '0;
      end else if (m_init) begin
         m_ack  = '0;
         m_done = '0;
         if (m_pend >= 0) begin
            m_ones[m_pend*4 +: 4] = 4'(m_op % 10);
            m_tens[m_pend*4 +: 4] = 4'(m_op / 10);
            m_valid[m_pend] = 1'b1;
            m_done[m_pend]  = 1'b1;
            m_pend = -1;
         end else if (req != 0) begin
            for (int k = 1; k <= CH; k++) begin
               int idx;
               idx = (m_last + k) % CH;
               if (m_pend < 0 && req[idx]) m_pend = idx;
            end
            m_op   = int'(operand[m_pend*6 +: 6]);
            m_last = m_pend;
            m_ack[m_pend] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_ack",   32'(ack),   32'(m_ack));
         chk("m_done",  32'(done),  32'(m_done));
         chk("m_busy",  32'(busy),  32'(m_pend >= 0));
         chk("m_ones",  32'(ones),  32'(m_ones));
         chk("m_tens",  32'(tens),  32'(m_tens));
         chk("m_valid", 32'(valid), 32'(m_valid));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_op(input int ch, input int v);
      operand[ch*6 +: 6] = 6'(v);
   endtask

   initial begin
      int exp_t[4];
      int exp_o[4];
      exp_t = '{1, 2, 3, 5};
      exp_o = '{0, 1, 2, 3};

      rst_n = 1'b0; req = '0; operand = '0;
      tick(3);
      chk("rst_ack",   32'(ack),   0);
      chk("rst_done",  32'(done),  0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_ones",  32'(ones),  0);
      chk("rst_tens",  32'(tens),  0);

      // single request: ch1 = 42
      rst_n = 1'b1; req = 4'b0010; set_op(1, 42);
      tick(1);
      chk("s_ack",  32'(ack), 32'b0010);
      chk("s_busy", 32'(busy), 1);
      chk("s_nodone", 32'(done), 0);
      req = '0;
      tick(1);
      chk("s_done",   32'(done), 32'b0010);
      chk("s_tens1",  32'(tens[7:4]), 4);
      chk("s_ones1",  32'(ones[7:4]), 2);
      chk("s_valid",  32'(valid), 32'b0010);
      chk("s_others", 32'({ones[15:8], ones[3:0], tens[15:8], tens[3:0]}), 0);
      chk("s_idle",   32'(busy), 0);

      // extremes on ch0
      set_op(0, 63); req = 4'b0001;
      tick(1); chk("x63_ack", 32'(ack), 32'b0001); req = '0;
      tick(1);
      chk("x63_tens", 32'(tens[3:0]), 6);
      chk("x63_ones", 32'(ones[3:0]), 3);
      set_op(0, 0); req = 4'b0001;
      tick(1); req = '0;
      tick(1);
      chk("x0_tens",  32'(tens[3:0]), 0);
      chk("x0_ones",  32'(ones[3:0]), 0);
      chk("x0_valid", 32'(valid), 32'b0011);

      // round-robin with all requesting from reset
      rst_n = 1'b0; req = 4'b1111;
      set_op(0, 10); set_op(1, 21); set_op(2, 32); set_op(3, 53);
      tick(2);
      rst_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         tick(1);
         chk("rr_ack", 32'(ack), 32'(1 << (g % 4)));
         tick(1);
         chk("rr_done", 32'(done), 32'(1 << (g % 4)));
         chk("rr_tens", 32'(tens[(g%4)*4 +: 4]), 32'(exp_t[g%4]));
         chk("rr_ones", 32'(ones[(g%4)*4 +: 4]), 32'(exp_o[g%4]));
      end

      // fairness after wrap: ch3 granted, then ch3+ch0 -> ch0
      req = 4'b1000;
      tick(1); chk("fw_ack3", 32'(ack), 32'b1000);
      tick(1); req = 4'b1001;
      tick(1); chk("fw_ack0", 32'(ack), 32'b0001);
      req = '0;
      tick(1);

      // withdrawn request keeps the sampled operand
      set_op(2, 37); req = 4'b0100;
      tick(1); chk("wd_ack", 32'(ack), 32'b0100);
      req = '0; set_op(2, 5);
      tick(1);
      chk("wd_done", 32'(done), 32'b0100);
      chk("wd_tens", 32'(tens[11:8]), 3);
      chk("wd_ones", 32'(ones[11:8]), 7);

      // reset during CONVERT
      set_op(1, 50); req = 4'b0010;
      tick(1); chk("mr_ack", 32'(ack), 32'b0010);
      rst_n = 1'b0; req = '0;
      tick(1);
      chk("mr_done",  32'(done), 0);
      chk("mr_valid", 32'(valid), 0);
      chk("mr_ones",  32'(ones), 0);
      chk("mr_tens",  32'(tens), 0);
      chk("mr_busy",  32'(busy), 0);
      rst_n = 1'b1; req = 4'b1111;
      tick(1); chk("mr_first", 32'(ack), 32'b0001);
      req = '0;
      tick(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         req     = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
         operand = 24'($urandom);
         tick(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
